instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 32 +++
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/instr_sequencer_fifo.sv | 60 ++++++
 rtl/instr_sequencer.sv | 153 +++++++++++++++
 tb/tb_instr_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer.
// Holds the 9-bit word width, the opcode constants of the IIIXXXYYY format,
// the sequencer FSM state enumeration and the immediate-type opcode decode.
package instr_sequencer_pkg;

  localparam int WORD_W = 9;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_SUBI = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_IMM   = 2'd2,
    ST_WAIT  = 2'd3
  } seq_state_e;

  // Immediate-type instructions consume the following buffer word as data.
  function automatic logic is_imm(input logic [WORD_W-1:0] w);
    logic [2:0] op;
    op = w[WORD_W-1 -: 3];
    case (op)
      OP_MVI, OP_ADDI, OP_SUBI: is_imm = 1'b1;
      default:                  is_imm = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Host/processor bus of the instruction sequencer.
// slave  : sequencer side (inputs wr_valid, wr_data, Start, Done;
//          outputs wr_ready, DIN, Run, Busy, Err, Count, Icount).
// master : environment side (host writer plus processor).
interface instr_sequencer_if #(parameter int DEPTH = 16) ();
  import instr_sequencer_pkg::*;

  logic                     wr_valid;
  logic [WORD_W-1:0]        wr_data;
  logic                     wr_ready;
  logic                     Start;
  logic [WORD_W-1:0]        DIN;
  logic                     Run;
  logic                     Done;
  logic                     Busy;
  logic                     Err;
  logic [$clog2(DEPTH):0]   Count;
  logic [7:0]               Icount;

  modport slave (
    input  wr_valid, wr_data, Start, Done,
    output wr_ready, DIN, Run, Busy, Err, Count, Icount
  );

  modport master (
    output wr_valid, wr_data, Start, Done,
    input  wr_ready, DIN, Run, Busy, Err, Count, Icount
  );
endinterface

// File: rtl/instr_sequencer_fifo.sv
// instr_fifo: synchronous FIFO holding instruction/immediate words.
// Ports: clk_i/rst_i (async active-high), wr_en_i/wr_data_i (write, dropped
// when full), rd_en_i (pop head), head_o (current head), next_o (word behind
// the head, valid when count_o >= 2), full_o, empty_o, count_o.
module instr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         next_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_nxt_s;
  logic [AW:0]      count_q;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign empty_o  = (count_q == (AW+1)'(0));
  assign do_wr_s  = wr_en_i && !full_o;
  assign do_rd_s  = rd_en_i && !empty_o;
  assign rd_nxt_s = rd_ptr_q + AW'(1);
  assign head_o   = mem_q[rd_ptr_q];
  assign next_o   = mem_q[rd_nxt_s];
  assign count_o  = count_q;

  // Pointer and occupancy registers; simultaneous push and pop keep the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      if (do_wr_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd_s) rd_ptr_q <= rd_nxt_s;
      case ({do_wr_s, do_rd_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are qualified by the pointers so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_wr_s) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers host-written instruction words and issues them to a
// processor, one Run strobe per instruction, waiting for Done between them.
// Ports: Clock, Reset (async active-high), bus (instr_sequencer_if.slave):
// host write channel, Start, processor Run/DIN/Done, status Busy/Err/Count/Icount.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TMO   = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  instr_sequencer_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TMO) + 1;

  seq_state_e         state_q, state_d;
  logic               active_q, active_d;
  logic               err_q, err_d;
  logic [7:0]         icount_q, icount_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               pop_s, retire_s, tmo_fire_s;
  logic [WORD_W-1:0]  head_s, head_nxt_s, din_s;
  logic               run_s, full_s, empty_s;
  logic [CW-1:0]      count_s;

  // A head is issuable once its whole instruction (plus immediate) is buffered.
  function automatic logic issuable(input logic [WORD_W-1:0] w, input logic [CW-1:0] n);
    if (is_imm(w)) issuable = (n >= CW'(2));
    else           issuable = (n >= CW'(1));
  endfunction

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clk_i     (Clock),
    .rst_i     (Reset),
    .wr_en_i   (bus.wr_valid),
    .wr_data_i (bus.wr_data),
    .rd_en_i   (pop_s),
    .head_o    (head_s),
    .next_o    (head_nxt_s),
    .full_o    (full_s),
    .empty_o   (empty_s),
    .count_o   (count_s)
  );

  // State, timeout and status registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      tmo_q    <= TW'(0);
      active_q <= 1'b0;
      err_q    <= 1'b0;
      icount_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      active_q <= active_d;
      err_q    <= err_d;
      icount_q <= icount_d;
    end
  end

  // Next-state logic; tmo_q counts cycles since the Run cycle.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    pop_s      = 1'b0;
    retire_s   = 1'b0;
    tmo_fire_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (active_q && issuable(head_s, count_s)) state_d = ST_ISSUE;
        else                                       state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        pop_s = 1'b1;
        tmo_d = TW'(1);
        if (is_imm(head_s)) state_d = ST_IMM;
        else                state_d = ST_WAIT;
      end
      ST_IMM: begin
        if (bus.Done) begin
          // The immediate leaves on this cycle, so look one word further.
          pop_s    = 1'b1;
          retire_s = 1'b1;
          if (issuable(head_nxt_s, count_s - CW'(1))) state_d = ST_ISSUE;
          else                                        state_d = ST_IDLE;
        end else if (tmo_q == TW'(TMO - 1)) begin
          tmo_fire_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_WAIT: begin
        if (bus.Done) begin
          retire_s = 1'b1;
          if (issuable(head_s, count_s)) state_d = ST_ISSUE;
          else                           state_d = ST_IDLE;
        end else if (tmo_q == TW'(TMO - 1)) begin
          tmo_fire_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Busy/Err/Icount updates; a timeout overrides a coincident Start.
  always_comb begin
    active_d = active_q;
    err_d    = err_q;
    icount_d = icount_q;
    if (tmo_fire_s) begin
      active_d = 1'b0;
      err_d    = 1'b1;
    end else if (bus.Start && !empty_s) begin
      active_d = 1'b1;
    end else if ((state_q == ST_IDLE) && empty_s) begin
      active_d = 1'b0;
    end else begin
      active_d = active_q;
    end
    if (retire_s) icount_d = icount_q + 8'd1;
    else          icount_d = icount_q;
  end

  // Output decode from the current state.
  always_comb begin
    run_s = 1'b0;
    din_s = {WORD_W{1'b0}};
    case (state_q)
      ST_ISSUE: begin
        run_s = 1'b1;
        din_s = head_s;
      end
      ST_IMM:  din_s = head_s;
      ST_WAIT: din_s = {WORD_W{1'b0}};
      default: din_s = {WORD_W{1'b0}};
    endcase
  end

  assign bus.Run      = run_s;
  assign bus.DIN      = din_s;
  assign bus.Busy     = active_q;
  assign bus.Err      = err_q;
  assign bus.Count    = count_s;
  assign bus.Icount   = icount_q;
  assign bus.wr_ready = !full_s;
endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
  localparam int DEPTH = 16;
  localparam int TMO   = 4;

  logic Clock = 1'b0;
  logic Reset;
  int   n_vec = 0;
  int   n_mis = 0;

  instr_sequencer_if #(.DEPTH(DEPTH)) bus();

  instr_sequencer #(.DEPTH(DEPTH), .TMO(TMO)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int unsigned mq[$];
  bit m_busy, m_err, m_issue, m_inflight, m_imm;
  int m_age, m_icount;

  function automatic bit imm_word(int unsigned w);
    int op;
    op = (w >> 6) & 7;
    return (op == 1) || (op == 4) || (op == 5);
  endfunction

  function automatic bit can_issue();
    if (mq.size() == 0) return 1'b0;
    if (imm_word(mq[0])) return mq.size() >= 2;
    return 1'b1;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_busy = 0; m_err = 0; m_issue = 0; m_inflight = 0; m_imm = 0;
    m_age = 0; m_icount = 0;
  endtask

  task automatic model_step(bit wv, int unsigned wd, bit st, bit dn);
    int n;
    bit fire, idle, nxt;
    n = mq.size(); fire = 0; nxt = 0;
    idle = !m_issue && !m_inflight;
    if (m_issue) begin
      m_imm = imm_word(mq[0]);
      void'(mq.pop_front());
      m_inflight = 1; m_age = 1;
    end else if (m_inflight) begin
      if (dn) begin
        m_icount = (m_icount + 1) % 256;
        if (m_imm) void'(mq.pop_front());
        m_inflight = 0;
        nxt = can_issue();
      end else if (m_age == TMO - 1) begin
        fire = 1; m_inflight = 0;
      end else begin
        m_age++;
      end
    end else begin
      nxt = m_busy && can_issue();
    end
    if (fire) begin m_err = 1; m_busy = 0; end
    else if (st && n > 0) m_busy = 1;
    else if (idle && n == 0) m_busy = 0;
    if (wv && n < DEPTH) mq.push_back(wd);
    m_issue = nxt;
  endtask

  // Compare process: outputs against the model every cycle, on the falling edge.
  initial begin
    int unsigned exp_din;
    model_clear();
    forever begin
      @(negedge Clock);
      if (Reset) model_clear();
      exp_din = 0;
      if (m_issue || (m_inflight && m_imm)) exp_din = mq[0];
      chk("cyc_Run",      16'(bus.Run),      16'(m_issue));
      chk("cyc_DIN",      16'(bus.DIN),      16'(exp_din));
      chk("cyc_Busy",     16'(bus.Busy),     16'(m_busy));
      chk("cyc_Err",      16'(bus.Err),      16'(m_err));
      chk("cyc_Count",    16'(bus.Count),    16'(mq.size()));
      chk("cyc_Icount",   16'(bus.Icount),   16'(m_icount));
      chk("cyc_wr_ready", 16'(bus.wr_ready), 16'(mq.size() < DEPTH));
      if (!Reset) model_step(bus.wr_valid, 32'(bus.wr_data), bus.Start, bus.Done);
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; bus.wr_valid = 1'b0; bus.Start = 1'b0; bus.Done = 1'b0;
    tick(); tick();
    Reset = 1'b0;
  endtask

  task automatic put(input logic [8:0] w);
    bus.wr_valid = 1'b1; bus.wr_data = w;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic start();
    bus.Start = 1'b1; tick(); bus.Start = 1'b0;
  endtask

  task automatic wait_run(input int budget, input string nm);
    int k;
    k = 0;
    while (bus.Run !== 1'b1 && k < budget) begin tick(); k++; end
    chk(nm, 16'(bus.Run), 16'd1);
  endtask

  initial begin
    bus.wr_valid = 1'b0; bus.wr_data = 9'd0; bus.Start = 1'b0; bus.Done = 1'b0;
    Reset = 1'b1;
    tick(); tick();
    chk("rst_wr_ready", 16'(bus.wr_ready), 16'd1);
    chk("rst_Count",    16'(bus.Count),    16'd0);
    chk("rst_Busy",     16'(bus.Busy),     16'd0);
    chk("rst_Err",      16'(bus.Err),      16'd0);
    chk("rst_Run",      16'(bus.Run),      16'd0);
    chk("rst_Icount",   16'(bus.Icount),   16'd0);
    Reset = 1'b0;

    // mvi with immediate
    do_reset();
    put(9'h040); put(9'h005); start();
    wait_run(4, "mvi_run");
    chk("mvi_din_instr", 16'(bus.DIN), 16'h040);
    tick();
    chk("mvi_run_one_cycle", 16'(bus.Run), 16'd0);
    chk("mvi_din_imm", 16'(bus.DIN), 16'h005);
    tick();
    chk("mvi_din_imm_held", 16'(bus.DIN), 16'h005);
    bus.Done = 1'b1; tick(); bus.Done = 1'b0;
    chk("mvi_icount", 16'(bus.Icount), 16'd1);
    chk("mvi_count", 16'(bus.Count), 16'd0);
    tick();
    chk("mvi_busy_off", 16'(bus.Busy), 16'd0);

    // two single-word instructions, Done at T1 and T3
    do_reset();
    put(9'h008); put(9'h081); start();
    wait_run(4, "mv_run");
    chk("mv_din", 16'(bus.DIN), 16'h008);
    tick();
    chk("mv_wait_din0", 16'(bus.DIN), 16'h000);
    bus.Done = 1'b1; tick(); bus.Done = 1'b0;
    chk("add_run_after_done", 16'(bus.Run), 16'd1);
    chk("add_din", 16'(bus.DIN), 16'h081);
    tick();
    chk("add_wait_din0_a", 16'(bus.DIN), 16'h000);
    tick();
    chk("add_wait_din0_b", 16'(bus.DIN), 16'h000);
    bus.Done = 1'b1; tick(); bus.Done = 1'b0;
    chk("add_icount", 16'(bus.Icount), 16'd2);
    chk("add_err", 16'(bus.Err), 16'd0);

    // immediate-type head stalls until its immediate arrives
    do_reset();
    put(9'h140); start();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_no_run", 16'(bus.Run), 16'd0);
      chk("stall_busy", 16'(bus.Busy), 16'd1);
    end
    put(9'h003);
    wait_run(3, "stall_run");
    chk("stall_din", 16'(bus.DIN), 16'h140);
    tick();
    chk("stall_imm", 16'(bus.DIN), 16'h003);
    bus.Done = 1'b1; tick(); bus.Done = 1'b0;

    // overfill
    do_reset();
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.wr_data = 9'(i);
      tick();
      if (i == 14) chk("fill15_ready", 16'(bus.wr_ready), 16'd1);
      if (i == 15) begin
        chk("fill16_ready", 16'(bus.wr_ready), 16'd0);
        chk("fill16_count", 16'(bus.Count), 16'd16);
      end
    end
    bus.wr_valid = 1'b0;
    chk("fill17_count", 16'(bus.Count), 16'd16);

    // Done timeout
    do_reset();
    put(9'h008); start();
    wait_run(4, "tmo_run");
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("tmo_err_early", 16'(bus.Err), 16'd0);
    end
    tick();
    chk("tmo_err", 16'(bus.Err), 16'd1);
    chk("tmo_busy", 16'(bus.Busy), 16'd0);
    chk("tmo_run", 16'(bus.Run), 16'd0);
    chk("tmo_din", 16'(bus.DIN), 16'h000);
    tick();
    chk("tmo_err_sticky", 16'(bus.Err), 16'd1);

    // reset during IMM
    do_reset();
    put(9'h008); put(9'h040); put(9'h005); start();
    wait_run(4, "rimm_run1");
    tick();
    bus.Done = 1'b1; tick(); bus.Done = 1'b0;
    chk("rimm_run2", 16'(bus.Run), 16'd1);
    chk("rimm_icount1", 16'(bus.Icount), 16'd1);
    tick();
    chk("rimm_in_imm", 16'(bus.DIN), 16'h005);
    #2 Reset = 1'b1;
    #1;
    chk("rimm_Run",    16'(bus.Run),    16'd0);
    chk("rimm_DIN",    16'(bus.DIN),    16'h000);
    chk("rimm_Count",  16'(bus.Count),  16'd0);
    chk("rimm_Icount", 16'(bus.Icount), 16'd0);
    chk("rimm_Err",    16'(bus.Err),    16'd0);
    chk("rimm_Busy",   16'(bus.Busy),   16'd0);
    tick();
    Reset = 1'b0;

    // randomized traffic in blocks with differing densities
    for (int blk = 0; blk < 8; blk++) begin
      int wr_pct, dn_pct;
      wr_pct = (blk % 3 == 0) ? 15 : ((blk % 3 == 1) ? 50 : 90);
      dn_pct = (blk % 4 == 0) ? 20 : ((blk % 4 == 1) ? 50 : ((blk % 4 == 2) ? 80 : 35));
      for (int c = 0; c < 400; c++) begin
        bus.wr_valid = ($urandom_range(0, 99) < wr_pct);
        bus.wr_data  = 9'($urandom_range(0, 511));
        bus.Start    = ($urandom_range(0, 7) == 0);
        bus.Done     = ($urandom_range(0, 99) < dn_pct);
        Reset        = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    Reset = 1'b0; bus.wr_valid = 1'b0; bus.Start = 1'b0; bus.Done = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
